kpscan: RTL
===========

Name: kpscan

Overview:
- Drives the keypad column selects and scans the four columns in turn.
- Samples the row lines, debounces the press and release, and emits one key event per press.
- Sits between the physical 4x4 keypad pins and the game FSM.
- Outputs a key code plus a start flag, using the same key mapping the keypad decode path uses.

Parameters:
- SCAN_DIV, 1000, clock cycles each column is held active during scanning; legal range 3 or more.
- DB_CYCLES, 20000, consecutive stable cycles required to accept a press or a release.
- REPEAT_DELAY, 500000, cycles from key acceptance to the first auto-repeat (optional feature only).
- REPEAT_RATE, 100000, cycles between later auto-repeats (optional feature only).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- kpr  in  4  keypad rows, active-low with pull-ups, asynchronous to clk.
- kpc  out  4  keypad column select, active-low one-hot.
- num  out  4  code of the last accepted key.
- strt  out  1  high together with key_valid when the accepted key is GO.
- key_valid  out  1  one-cycle pulse when a key is accepted.
- key_held  out  1  high from acceptance until the release is debounced.

Behaviour:
- Reset (async assert, sync deassert):
  - kpc=4'b0111, num=0, strt=0, key_valid=0, key_held=0.
  - Dwell and debounce counters cleared; state SCAN; synchronizer flops set to 1111.
- Input sync: kpr passes through a 2-flop synchronizer (kpr_s). All decisions use kpr_s.
- Key mapping:
  - Row r is the low bit of kpr at position 3-r; column c is the low bit of kpc at position 3-c.
  - r0: 1,2,3,A. r1: 4,5,6,B. r2: 7,8,9,C. r3: E,0,F,D.
  - strt=1 only for code B.
- SCAN:
  - The column rotates every SCAN_DIV cycles: 0111 -> 1011 -> 1101 -> 1110 -> 0111 (wraps).
  - kpr_s is examined only on the last cycle of each dwell.
  - Exactly one row low: latch row and column, freeze kpc, clear the counter, go to DEBOUNCE.
  - kpr_s=1111, or two or more rows low: no action, continue scanning.
- DEBOUNCE:
  - kpc stays frozen; kpr_s is compared with the latched row every cycle.
  - Mismatch: return to SCAN at the next column with a fresh dwell; no event.
  - Match for DB_CYCLES consecutive cycles: on that cycle pulse key_valid for one cycle, update num and strt, set key_held=1, go to HELD.
- HELD:
  - kpc stays frozen.
  - Release counter counts consecutive cycles with kpr_s=1111; any other value clears it.
  - Count reaches DB_CYCLES: key_held=0, go to SCAN at the next column.
  - No further key_valid pulses in this state (unless the optional feature is enabled).
- num and strt hold their last value until the next acceptance. strt is registered with num but is meaningful only alongside key_valid.
- Counter widths come from $clog2 of each parameter. Counters saturate; they never wrap.
- Reset mid-operation: everything returns to reset values immediately; no event is emitted.

Optional Feature:
- KPSCAN_REPEAT_EN defined:
  - In HELD, the first extra key_valid pulse (same num and strt) fires REPEAT_DELAY cycles after acceptance.
  - Further pulses follow every REPEAT_RATE cycles while held.
  - Any cycle with kpr_s != latched row restarts the repeat timing.
  - Release behaviour is unchanged.
- Undefined: exactly one key_valid pulse per press; repeat counters and parameters are unused.

Test Plan:
- Use SCAN_DIV=4, DB_CYCLES=8 for all scenarios.
- Reset, then kpr=1111 -> kpc=0111 for cycles 0-3, 1011 for 4-7, 1101, 1110, back to 0111 at cycle 16; key_valid never asserts.
- Key 5 (kpr=1011 only while kpc=1011), held steady -> kpc frozen at 1011; a single key_valid pulse 8 cycles after entering DEBOUNCE with num=5, strt=0; key_held=1.
- GO with one kpr=1111 glitch at debounce cycle 3 -> no pulse, scanning resumes at kpc=1110/0111; a later stable press gives one pulse with num=B, strt=1.
- Release of held key 0 with 5 cycles of bounce -> key_held stays 1 until 8 consecutive 1111 cycles, then drops; no second key_valid.
- kpr=0011 during a column dwell -> no DEBOUNCE entry, no pulse, rotation continues.
- reset_n low during HELD -> kpc=0111, key_held=0, key_valid=0 within the same cycle; with KPSCAN_REPEAT_EN, REPEAT_DELAY=20, REPEAT_RATE=10, a held key gives pulses at acceptance +20, +30, +40.

Source files
------------

// File: rtl/kpscan.sv
// rtl/kpscan.sv - 4x4 keypad column scanner with debounced press/release and one event per press
// Optional auto-repeat while a key is held: define KPSCAN_REPEAT_EN.
module kpscan #(
    parameter int SCAN_DIV     = 1000,
    parameter int DB_CYCLES    = 20000,
    parameter int REPEAT_DELAY = 500000,
    parameter int REPEAT_RATE  = 100000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] kpr,
    output logic [3:0] kpc,
    output logic [3:0] num,
    output logic       strt,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DB_LAST    = BW'(DB_CYCLES - 1);
`ifdef KPSCAN_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);
`endif

    if (SCAN_DIV < 3 || DB_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
        $error("kpscan: illegal parameter value");
    end

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    function automatic logic one_low(input logic [3:0] v);
        case (v)
            4'b0111, 4'b1011, 4'b1101, 4'b1110: one_low = 1'b1;
            default:                            one_low = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] v);
        case (v)
            4'b1011: low_index = 2'd1;
            4'b1101: low_index = 2'd2;
            4'b1110: low_index = 2'd3;
            default: low_index = 2'd0;
        endcase
    endfunction

    // Same row/column-to-code table as the keypad decode path.
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: key_code = 4'h1;  4'h1: key_code = 4'h2;  4'h2: key_code = 4'h3;  4'h3: key_code = 4'hA;
            4'h4: key_code = 4'h4;  4'h5: key_code = 4'h5;  4'h6: key_code = 4'h6;  4'h7: key_code = 4'hB;
            4'h8: key_code = 4'h7;  4'h9: key_code = 4'h8;  4'hA: key_code = 4'h9;  4'hB: key_code = 4'hC;
            4'hC: key_code = 4'hE;  4'hD: key_code = 4'h0;  4'hE: key_code = 4'hF;  default: key_code = 4'hD;
        endcase
    endfunction

    logic [1:0] rst_sync;
    logic       rst_n;

    // Reset asserts asynchronously, releases on a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    state_t          state, state_nxt;
    logic [3:0]      kpr_m, kpr_s;
    logic [3:0]      row, row_nxt;
    logic [3:0]      kpc_nxt, num_nxt, code;
    logic            strt_nxt, key_valid_nxt, key_held_nxt;
    logic [DW-1:0]   dwell, dwell_nxt;
    logic [BW-1:0]   db_cnt, db_cnt_nxt;
`ifdef KPSCAN_REPEAT_EN
    logic [RW-1:0]   rep_cnt, rep_cnt_nxt;
    logic            rep_first, rep_first_nxt;
`endif

    assign code = key_code(low_index(row), low_index(kpc));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kpr_m     <= 4'b1111;
            kpr_s     <= 4'b1111;
            state     <= SCAN;
            kpc       <= 4'b0111;
            row       <= 4'b1111;
            num       <= 4'h0;
            strt      <= 1'b0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            dwell     <= '0;
            db_cnt    <= '0;
`ifdef KPSCAN_REPEAT_EN
            rep_cnt   <= '0;
            rep_first <= 1'b1;
`endif
        end else begin
            kpr_m     <= kpr;
            kpr_s     <= kpr_m;
            state     <= state_nxt;
            kpc       <= kpc_nxt;
            row       <= row_nxt;
            num       <= num_nxt;
            strt      <= strt_nxt;
            key_valid <= key_valid_nxt;
            key_held  <= key_held_nxt;
            dwell     <= dwell_nxt;
            db_cnt    <= db_cnt_nxt;
`ifdef KPSCAN_REPEAT_EN
            rep_cnt   <= rep_cnt_nxt;
            rep_first <= rep_first_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt     = state;
        kpc_nxt       = kpc;
        row_nxt       = row;
        num_nxt       = num;
        strt_nxt      = strt;
        key_valid_nxt = 1'b0;
        key_held_nxt  = key_held;
        dwell_nxt     = dwell;
        db_cnt_nxt    = db_cnt;
`ifdef KPSCAN_REPEAT_EN
        rep_cnt_nxt   = rep_cnt;
        rep_first_nxt = rep_first;
`endif
        case (state)
            SCAN: begin
                if (dwell == DWELL_LAST) begin
                    dwell_nxt = '0;
                    if (one_low(kpr_s)) begin
                        row_nxt    = kpr_s;
                        db_cnt_nxt = '0;
                        state_nxt  = DEBOUNCE;
                    end else begin
                        kpc_nxt = {kpc[0], kpc[3:1]};
                    end
                end else begin
                    dwell_nxt = dwell + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (kpr_s != row) begin
                    state_nxt = SCAN;
                    kpc_nxt   = {kpc[0], kpc[3:1]};
                    dwell_nxt = '0;
                end else if (db_cnt == DB_LAST) begin
                    key_valid_nxt = 1'b1;
                    num_nxt       = code;
                    strt_nxt      = (code == 4'hB);
                    key_held_nxt  = 1'b1;
                    db_cnt_nxt    = '0;
                    state_nxt     = HELD;
`ifdef KPSCAN_REPEAT_EN
                    rep_cnt_nxt   = '0;
                    rep_first_nxt = 1'b1;
`endif
                end else begin
                    db_cnt_nxt = db_cnt + 1'b1;
                end
            end
            HELD: begin
                if (kpr_s == 4'b1111) begin
                    if (db_cnt == DB_LAST) begin
                        key_held_nxt = 1'b0;
                        state_nxt    = SCAN;
                        kpc_nxt      = {kpc[0], kpc[3:1]};
                        dwell_nxt    = '0;
                        db_cnt_nxt   = '0;
                    end else begin
                        db_cnt_nxt = db_cnt + 1'b1;
                    end
                end else begin
                    db_cnt_nxt = '0;
                end
`ifdef KPSCAN_REPEAT_EN
                // Any disturbance of the held row restarts the repeat timing from the initial delay.
                if (kpr_s != row) begin
                    rep_cnt_nxt   = '0;
                    rep_first_nxt = 1'b1;
                end else if (rep_cnt == (rep_first ? DELAY_LAST : RATE_LAST)) begin
                    key_valid_nxt = 1'b1;
                    rep_cnt_nxt   = '0;
                    rep_first_nxt = 1'b0;
                end else begin
                    rep_cnt_nxt = rep_cnt + 1'b1;
                end
`endif
            end
            default: begin
                state_nxt = SCAN;
                kpc_nxt   = 4'b0111;
                dwell_nxt = '0;
            end
        endcase
    end

endmodule
